// File: rtl/pet_figure_sequencer_if.sv
// Handshake bundle between the pet state logic, the figure sequencer and the LCD figure driver.
interface pet_figure_sequencer_if;
  logic [2:0] lvl_energia;
  logic [2:0] lvl_diversion;
  logic [2:0] lvl_alimento;
  logic [2:0] lvl_salud;
  logic       lcd_busy;
  logic [3:0] select_figures;
  logic       figure_valid;
  logic       critical;

  modport master (
    output lvl_energia, lvl_diversion, lvl_alimento, lvl_salud, lcd_busy,
    input  select_figures, figure_valid, critical
  );

  modport slave (
    input  lvl_energia, lvl_diversion, lvl_alimento, lvl_salud, lcd_busy,
    output select_figures, figure_valid, critical
  );
endinterface

// File: rtl/pet_figure_sequencer.sv
// Picks the face and rotating indicator shown on the LCD and publishes changes when the LCD is idle.
// Optional: define SEQ_ALERT_PRIORITY_EN to make critical indicators preempt and restrict the rotation.
module pet_figure_sequencer #(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter logic [2:0]  LOW_TH       = 3'd1,
  parameter logic [2:0]  HIGH_TH      = 3'd4,
  parameter logic [2:0]  MAX_LEVEL    = 3'd5
) (
  input  logic                   clk,
  input  logic                   reset,
  pet_figure_sequencer_if.slave  bus
);

  localparam int unsigned         CNT_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [1:0]          FACE_FELIZ  = 2'b00;
  localparam logic [1:0]          FACE_TRISTE = 2'b01;
  localparam logic [1:0]          FACE_NEUTRO = 2'b10;
  localparam logic [3:0]          SEL_RESET   = {FACE_NEUTRO, 2'b00};

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_PICK = 2'd1,
    S_WAIT = 2'd2,
    S_PUB  = 2'd3
  } state_t;

  function automatic logic [2:0] sat_level(input logic [2:0] lvl);
    return (lvl > MAX_LEVEL) ? MAX_LEVEL : lvl;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_sel;
  logic [3:0]       w_sel_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic [1:0]       r_pend_idx;
  logic [1:0]       w_pend_nxt;
  logic             r_crit;
  logic [1:0]       w_pick_idx;
  logic [2:0]       w_sat [4];
  logic [3:0]       w_crit_mask;
  logic             w_all_high;
  logic [1:0]       w_face;

  // Saturate the sampled levels and classify them into a face.
  always_comb begin
    w_sat[0]    = sat_level(bus.lvl_energia);
    w_sat[1]    = sat_level(bus.lvl_diversion);
    w_sat[2]    = sat_level(bus.lvl_alimento);
    w_sat[3]    = sat_level(bus.lvl_salud);
    w_crit_mask = 4'b0000;
    w_all_high  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_crit_mask[i] = (w_sat[i] <= LOW_TH);
      if (w_sat[i] < HIGH_TH) begin
        w_all_high = 1'b0;
      end
    end
    if (|w_crit_mask) begin
      w_face = FACE_TRISTE;
    end else if (w_all_high) begin
      w_face = FACE_FELIZ;
    end else begin
      w_face = FACE_NEUTRO;
    end
  end

`ifdef SEQ_ALERT_PRIORITY_EN
  logic [3:0] r_crit_mask;
  logic       r_jump;
  logic       w_jump_nxt;
  logic       w_crit_rise;

  // First set bit of mask at or after start, wrapping; falls back to start when mask is empty.
  function automatic logic [1:0] next_in_mask(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign w_crit_rise = (|w_crit_mask) & ~r_crit;
  assign w_pick_idx  = r_jump ? next_in_mask(r_crit_mask, 2'd0)
                              : next_in_mask(r_crit_mask, r_sel[1:0] + 2'd1);
`else
  assign w_pick_idx  = r_sel[1:0] + 2'd1;
`endif

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_valid_nxt = 1'b0;
    w_pend_nxt  = r_pend_idx;
`ifdef SEQ_ALERT_PRIORITY_EN
    w_jump_nxt  = r_jump;
`endif
    case (r_state)
      S_HOLD: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_PICK;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
`ifdef SEQ_ALERT_PRIORITY_EN
        if (w_crit_rise) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_PICK;
          w_jump_nxt  = 1'b1;
        end
`endif
      end
      S_PICK: begin
        w_pend_nxt = w_pick_idx;
`ifdef SEQ_ALERT_PRIORITY_EN
        w_jump_nxt = 1'b0;
`endif
        if ({w_face, w_pick_idx} == r_sel) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Face is taken from the levels seen as the LCD frees up, not when the dwell expired.
        if (!bus.lcd_busy) begin
          w_state_nxt = S_PUB;
          w_sel_nxt   = {w_face, r_pend_idx};
          w_valid_nxt = 1'b1;
        end
      end
      S_PUB: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_HOLD;
      end
      default: begin
        w_state_nxt = S_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_HOLD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt       <= '0;
      r_sel       <= SEL_RESET;
      r_valid     <= 1'b0;
      r_pend_idx  <= 2'b00;
      r_crit      <= 1'b0;
`ifdef SEQ_ALERT_PRIORITY_EN
      r_crit_mask <= 4'b0000;
      r_jump      <= 1'b0;
`endif
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_sel       <= w_sel_nxt;
      r_valid     <= w_valid_nxt;
      r_pend_idx  <= w_pend_nxt;
      r_crit      <= |w_crit_mask;
`ifdef SEQ_ALERT_PRIORITY_EN
      r_crit_mask <= w_crit_mask;
      r_jump      <= w_jump_nxt;
`endif
    end
  end

  assign bus.select_figures = r_sel;
  assign bus.figure_valid   = r_valid;
  assign bus.critical       = r_crit;

endmodule

// File: tb/tb_pet_figure_sequencer.sv
// Randomised self-checking bench for pet_figure_sequencer against a publish-timeline reference model.
module tb_pet_figure_sequencer;
  localparam int DWELL = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pet_figure_sequencer_if bus ();

  pet_figure_sequencer #(.DWELL_CYCLES(DWELL)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: expected outputs derived from dwell expiry / publish edge timestamps.
  logic [3:0] m_sel;
  logic       m_valid;
  logic       m_crit;
  int         m_edge, m_expiry, m_pub_from, m_nxt;

  function automatic int sat(input logic [2:0] l);
    return (int'(l) > 5) ? 5 : int'(l);
  endfunction

  function automatic logic crit_of(input logic [2:0] e, d, a, s);
    return (sat(e) <= 1) || (sat(d) <= 1) || (sat(a) <= 1) || (sat(s) <= 1);
  endfunction

  function automatic logic [1:0] face_of(input logic [2:0] e, d, a, s);
    if (crit_of(e, d, a, s)) return 2'b01;
    if (sat(e) >= 4 && sat(d) >= 4 && sat(a) >= 4 && sat(s) >= 4) return 2'b00;
    return 2'b10;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel = 4'b1000; m_valid = 1'b0; m_crit = 1'b0;
      m_edge = 0; m_expiry = DWELL; m_pub_from = -1;
    end else begin
      m_edge++;
      m_valid = 1'b0;
      if (m_pub_from >= 0 && m_edge >= m_pub_from && !bus.lcd_busy) begin
        m_nxt = (int'(m_sel[1:0]) + 1) % 4;
        m_sel = {face_of(bus.lvl_energia, bus.lvl_diversion, bus.lvl_alimento, bus.lvl_salud), 2'(m_nxt)};
        m_valid = 1'b1;
        m_pub_from = -1;
        m_expiry = m_edge + DWELL + 1;
      end else if (m_pub_from < 0 && m_edge == m_expiry) begin
        m_pub_from = m_edge + 2;
      end
      m_crit = crit_of(bus.lvl_energia, bus.lvl_diversion, bus.lvl_alimento, bus.lvl_salud);
    end
  end

  task automatic set_levels(input logic [2:0] e, d, a, s);
    bus.lvl_energia = e; bus.lvl_diversion = d; bus.lvl_alimento = a; bus.lvl_salud = s;
  endtask

  task automatic test_reset();
    int lat;
    set_levels(3'd3, 3'd3, 3'd3, 3'd3);
    bus.lcd_busy = 1'b0;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++; if (bus.select_figures !== 4'b1000) begin n_errors++; $display("FAIL reset_sel got %b exp 1000", bus.select_figures); end
    n_checks++; if (bus.figure_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b exp 0", bus.figure_valid); end
    n_checks++; if (bus.critical !== 1'b0) begin n_errors++; $display("FAIL reset_crit got %b exp 0", bus.critical); end
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.select_figures !== m_sel) begin n_errors++; $display("FAIL release_sel k=%0d got %b exp %b", k, bus.select_figures, m_sel); end
      n_checks++; if (bus.figure_valid !== m_valid) begin n_errors++; $display("FAIL release_valid k=%0d got %b exp %b", k, bus.figure_valid, m_valid); end
      if (bus.figure_valid === 1'b1) lat = k;
    end
    n_checks++; if (lat != DWELL + 2) begin n_errors++; $display("FAIL first_strobe_latency got %0d exp %0d", lat, DWELL + 2); end
    n_checks++; if (bus.select_figures !== 4'b1001) begin n_errors++; $display("FAIL first_publish got %b exp 1001", bus.select_figures); end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_sel;
    int         got;
    set_levels(3'd5, 3'd5, 3'd5, 3'd5);
    got = 0;
    for (int k = 0; k < 60 && got < 4; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.select_figures !== m_sel) begin n_errors++; $display("FAIL rot_sel t=%0t got %b exp %b", $time, bus.select_figures, m_sel); end
      n_checks++; if (bus.figure_valid !== m_valid) begin n_errors++; $display("FAIL rot_valid t=%0t got %b exp %b", $time, bus.figure_valid, m_valid); end
      if (bus.figure_valid === 1'b1) begin
        exp_sel = {2'b00, 2'((2 + got) % 4)};
        n_checks++; if (bus.select_figures !== exp_sel) begin n_errors++; $display("FAIL rot_order n=%0d got %b exp %b", got, bus.select_figures, exp_sel); end
        got++;
      end
    end
    n_checks++; if (got != 4) begin n_errors++; $display("FAIL rot_count got %0d exp 4", got); end
  endtask

  task automatic test_critical();
    int seen;
    set_levels(3'd3, 3'd3, 3'd3, 3'd0);
    @(posedge clk); #1;
    n_checks++; if (bus.critical !== 1'b1) begin n_errors++; $display("FAIL crit_rise got %b exp 1", bus.critical); end
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.select_figures !== m_sel) begin n_errors++; $display("FAIL crit_sel t=%0t got %b exp %b", $time, bus.select_figures, m_sel); end
      n_checks++; if (bus.critical !== m_crit) begin n_errors++; $display("FAIL crit_flag t=%0t got %b exp %b", $time, bus.critical, m_crit); end
      if (bus.figure_valid === 1'b1) seen = 1;
    end
    n_checks++; if (seen == 0 || bus.select_figures[3:2] !== 2'b01) begin n_errors++; $display("FAIL crit_face seen=%0d got %b exp 01", seen, bus.select_figures[3:2]); end
  endtask

  task automatic test_busy();
    logic [3:0] held;
    int         seen;
    set_levels(3'd2, 3'd4, 3'd5, 3'd3);
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (bus.figure_valid === 1'b1) seen = 1;
    end
    n_checks++; if (seen == 0) begin n_errors++; $display("FAIL busy_sync got none exp strobe"); end
    held = bus.select_figures;
    bus.lcd_busy = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      n_checks++; if (bus.select_figures !== held || bus.figure_valid !== 1'b0) begin n_errors++; $display("FAIL busy_hold got %b/%b exp %b/0", bus.select_figures, bus.figure_valid, held); end
    end
    bus.lcd_busy = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.figure_valid !== 1'b1) begin n_errors++; $display("FAIL busy_release_valid got %b exp 1", bus.figure_valid); end
    n_checks++; if (bus.select_figures !== m_sel) begin n_errors++; $display("FAIL busy_release_sel got %b exp %b", bus.select_figures, m_sel); end
    repeat (DWELL + 3) begin
      @(posedge clk); #1;
      n_checks++; if (bus.figure_valid !== m_valid) begin n_errors++; $display("FAIL busy_restart_valid t=%0t got %b exp %b", $time, bus.figure_valid, m_valid); end
    end
  endtask

  task automatic test_reset_mid_wait();
    int lat;
    bus.lcd_busy = 1'b1;
    repeat (2 * DWELL + 6) @(posedge clk);
    #1;
    n_checks++; if (m_pub_from < 0) begin n_errors++; $display("FAIL midwait_setup got idle exp waiting"); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.select_figures !== 4'b1000 || bus.figure_valid !== 1'b0) begin n_errors++; $display("FAIL midwait_reset got %b/%b exp 1000/0", bus.select_figures, bus.figure_valid); end
    bus.lcd_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      @(posedge clk); #1;
      n_checks++; if (bus.select_figures !== m_sel) begin n_errors++; $display("FAIL midwait_sel k=%0d got %b exp %b", k, bus.select_figures, m_sel); end
      if (bus.figure_valid === 1'b1) lat = k;
    end
    n_checks++; if (lat != DWELL + 2) begin n_errors++; $display("FAIL midwait_latency got %0d exp %0d", lat, DWELL + 2); end
  endtask

  task automatic test_saturation();
    int seen;
    set_levels(3'd7, 3'd5, 3'd5, 3'd5);
    @(posedge clk); #1;
    n_checks++; if (bus.critical !== 1'b0) begin n_errors++; $display("FAIL sat_crit got %b exp 0", bus.critical); end
    seen = 0;
    for (int k = 0; k < 30 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (bus.figure_valid === 1'b1) seen = 1;
    end
    n_checks++; if (seen == 0 || bus.select_figures[3:2] !== 2'b00) begin n_errors++; $display("FAIL sat_face seen=%0d got %b exp 00", seen, bus.select_figures[3:2]); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0)
        set_levels(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      bus.lcd_busy = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      n_checks++; if (bus.select_figures !== m_sel) begin n_errors++; $display("FAIL rand_sel t=%0t got %b exp %b", $time, bus.select_figures, m_sel); end
      n_checks++; if (bus.figure_valid !== m_valid) begin n_errors++; $display("FAIL rand_valid t=%0t got %b exp %b", $time, bus.figure_valid, m_valid); end
      n_checks++; if (bus.critical !== m_crit) begin n_errors++; $display("FAIL rand_crit t=%0t got %b exp %b", $time, bus.critical, m_crit); end
    end
    bus.lcd_busy = 1'b0;
  endtask

  initial begin
    set_levels(3'd3, 3'd3, 3'd3, 3'd3);
    bus.lcd_busy = 1'b0;
    test_reset();
    test_rotation();
    test_critical();
    test_busy();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
